// File: rtl/net_sched_if.sv
// net_sched_if: host start/status, DRAM descriptor read port and the
// conv/pool engine launch/done handshakes of the layer sequencer.
// master = the sequencer, slave = its environment (host, DRAM, engines).
interface net_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int IDX_W      = 3
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  dram_en_rd;
  logic                  conv_enable;
  logic                  conv_done;
  logic                  pool_enable;
  logic                  pool_done;
  logic [IDX_W-1:0]      layer_idx;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, data_in, conv_done, pool_done,
    output addr_in, dram_en_rd, conv_enable, pool_enable, layer_idx, busy, done, err
  );

  modport slave (
    output start, data_in, conv_done, pool_done,
    input  addr_in, dram_en_rd, conv_enable, pool_enable, layer_idx, busy, done, err
  );
endinterface

// File: rtl/net_sched.sv
// net_sched: top-level CNN layer sequencer. Fetches one descriptor per layer
// from DRAM, launches conv and/or pool and waits for their done pulses.
// Optional build macro SCHED_WDOG_EN adds a wait-state watchdog that aborts
// the run with err after WDOG_CYCLES cycles without the awaited done.
module net_sched #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 18,
  parameter logic [ADDR_WIDTH-1:0] LAYER_TBL_BASE = 18'd32,
  parameter int                    MAX_LAYERS     = 8,
  parameter int                    WDOG_CYCLES    = 1048575,
  localparam int                   IDX_W          = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic        clk,
  input  logic        srstn,
  net_sched_if.master bus
);

  typedef enum logic [8:0] {
    S_IDLE      = 9'b000000001,
    S_FETCH     = 9'b000000010,
    S_DECODE    = 9'b000000100,
    S_CONV_GO   = 9'b000001000,
    S_CONV_WAIT = 9'b000010000,
    S_POOL_GO   = 9'b000100000,
    S_POOL_WAIT = 9'b001000000,
    S_NEXT      = 9'b010000000,
    S_DONE      = 9'b100000000
  } state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] layer_idx;
  logic [1:0]       op_reg;
  logic             err;
  logic             err_set;
  logic             last_layer;
  logic             wdog_hit;

  assign last_layer = (layer_idx == IDX_W'(MAX_LAYERS - 1));

`ifdef SCHED_WDOG_EN
  logic [19:0] wdog_cnt;

  // Cycle count inside a wait state; any other state clears it, so it
  // restarts from zero on every entry to CONV_WAIT or POOL_WAIT.
  always_ff @(posedge clk) begin
    if (!srstn)
      wdog_cnt <= '0;
    else if (state == S_CONV_WAIT || state == S_POOL_WAIT)
      wdog_cnt <= wdog_cnt + 20'd1;
    else
      wdog_cnt <= '0;
  end

  // Fires in the WDOG_CYCLES-th consecutive wait cycle.
  assign wdog_hit = (wdog_cnt == 20'(WDOG_CYCLES - 1));
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
`endif

  // Descriptor bits above the op field are reserved.
  logic unused_rsvd;
  assign unused_rsvd = ^bus.data_in[DATA_WIDTH-1:2];

  // State register.
  always_ff @(posedge clk) begin
    if (!srstn) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; err_set flags the two abort paths into DONE.
  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    case (state)
      S_IDLE:      if (bus.start) next_state = S_FETCH;
      S_FETCH:     next_state = S_DECODE;
      S_DECODE: begin
        case (bus.data_in[1:0])
          2'd0:    next_state = S_DONE;
          2'd2:    next_state = S_POOL_GO;
          default: next_state = S_CONV_GO;
        endcase
      end
      S_CONV_GO:   next_state = S_CONV_WAIT;
      S_CONV_WAIT: begin
        if (bus.conv_done)
          next_state = (op_reg == 2'd3) ? S_POOL_GO : S_NEXT;
        else if (wdog_hit) begin
          err_set    = 1'b1;
          next_state = S_DONE;
        end
      end
      S_POOL_GO:   next_state = S_POOL_WAIT;
      S_POOL_WAIT: begin
        if (bus.pool_done)
          next_state = S_NEXT;
        else if (wdog_hit) begin
          err_set    = 1'b1;
          next_state = S_DONE;
        end
      end
      S_NEXT: begin
        if (last_layer) begin
          err_set    = 1'b1;
          next_state = S_DONE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Layer index, latched op and sticky error.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      layer_idx <= '0;
      op_reg    <= '0;
      err       <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        layer_idx <= '0;
        err       <= 1'b0;
      end
      if (state == S_DECODE)
        op_reg <= bus.data_in[1:0];
      if (state == S_NEXT && !last_layer)
        layer_idx <= layer_idx + IDX_W'(1);
      if (err_set)
        err <= 1'b1;
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.dram_en_rd  = (state == S_FETCH);
  assign bus.addr_in     = (state == S_FETCH) ? LAYER_TBL_BASE + ADDR_WIDTH'(layer_idx) : '0;
  assign bus.conv_enable = (state == S_CONV_GO);
  assign bus.pool_enable = (state == S_POOL_GO);
  assign bus.done        = (state == S_DONE);
  assign bus.layer_idx   = layer_idx;
  assign bus.err         = err;

endmodule

// File: tb/tb_net_sched.sv
// tb_net_sched: randomized descriptor tables and engine latencies. A timeline
// model derived from the sequencing rules predicts every output on every
// cycle of a run; the engines answer at the model's predicted done cycles and
// stray done pulses / start pulses are injected where they must be ignored.
module tb_net_sched;
  localparam int DW   = 32;
  localparam int AW   = 18;
  localparam int NL   = 8;
  localparam int IW   = 3;
  localparam int MAXC = 512;
`ifdef SCHED_WDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 1048575;
`endif

  logic clk = 1'b0;
  logic srstn;

  net_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDX_W(IW)) bus ();

  net_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAYER_TBL_BASE(18'd32),
    .MAX_LAYERS(NL), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .srstn(srstn), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  // Scenario: table ops and per-layer engine latencies.
  logic [1:0] tbl [NL];
  int         lc  [NL];
  int         lp  [NL];

  // Model timeline, indexed by cycle relative to the start cycle (0).
  logic [26:0] e_out [MAXC];
  bit          cdrv  [MAXC];
  bit          pdrv  [MAXC];
  bit          cwait [MAXC];
  bit          pwait [MAXC];
  int          e_end;
  bit          rd_q;

  // {busy, done, err, rd, conv_en, pool_en, layer_idx[2:0], addr[17:0]}
  function automatic logic [26:0] mk(bit b, bit d, bit e, bit r, bit cv, bit pl, int idx, int addr);
    return {b, d, e, r, cv, pl, 3'(idx), 18'(addr)};
  endfunction

  function automatic logic [26:0] obs();
    return {bus.busy, bus.done, bus.err, bus.dram_en_rd, bus.conv_enable,
            bus.pool_enable, bus.layer_idx, bus.addr_in};
  endfunction

  // Layer-by-layer timeline: fetch t+1, decode t+2, launch t+3, engine
  // answers L cycles after launch, one NEXT cycle, then the next fetch.
  task automatic build();
    int t = 0, c = 0, idx = 0;
    bit fin = 0, er = 0;
    for (int i = 0; i < MAXC; i++) begin
      e_out[i] = '0; cdrv[i] = 0; pdrv[i] = 0; cwait[i] = 0; pwait[i] = 0;
    end
    while (!fin) begin
      e_out[t+1] = mk(1, 0, 0, 1, 0, 0, idx, 32 + idx);
      e_out[t+2] = mk(1, 0, 0, 0, 0, 0, idx, 0);
      c = t + 3;
      if (tbl[idx] == 2'd0) begin
        e_out[c] = mk(1, 1, 0, 0, 0, 0, idx, 0);
        e_end = c; fin = 1;
      end else begin
        if (tbl[idx][0]) begin
          e_out[c] = mk(1, 0, 0, 0, 1, 0, idx, 0);
          for (int k = 1; k <= lc[idx]; k++) begin
            e_out[c+k] = mk(1, 0, 0, 0, 0, 0, idx, 0); cwait[c+k] = 1;
          end
          cdrv[c+lc[idx]] = 1;
          c = c + lc[idx] + 1;
        end
        if (tbl[idx][1]) begin
          e_out[c] = mk(1, 0, 0, 0, 0, 1, idx, 0);
          for (int k = 1; k <= lp[idx]; k++) begin
            e_out[c+k] = mk(1, 0, 0, 0, 0, 0, idx, 0); pwait[c+k] = 1;
          end
          pdrv[c+lp[idx]] = 1;
          c = c + lp[idx] + 1;
        end
        e_out[c] = mk(1, 0, 0, 0, 0, 0, idx, 0);
        if (idx == NL - 1) begin
          er = 1;
          e_out[c+1] = mk(1, 1, 1, 0, 0, 0, idx, 0);
          e_end = c + 1; fin = 1;
        end else begin
          t = c; idx++;
        end
      end
    end
    e_out[e_end+1] = mk(0, 0, er, 0, 0, 0, idx, 0);
  endtask

  // DRAM answers the cycle after the fetch; upper descriptor bits are junk.
  function automatic logic [31:0] mem_word(logic [AW-1:0] a);
    logic [31:0] w = $urandom;
    if (a >= 18'd32 && a < 18'd40) w[1:0] = tbl[a - 18'd32];
    return w;
  endfunction

  task automatic step(input bit st, input bit cd, input bit pd);
    bus.start     = st;
    bus.conv_done = cd;
    bus.pool_done = pd;
    if (bus.dram_en_rd) bus.data_in = mem_word(bus.addr_in);
    else if (!rd_q)     bus.data_in = $urandom;
    rd_q = bus.dram_en_rd;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle", {bus.busy, bus.done, bus.conv_enable, bus.pool_enable, bus.dram_en_rd}, 0);
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
  endtask

  // One network run; rst_at >= 0 pulls srstn low in that cycle.
  task automatic run(input string nm, input bit noise, input int rst_at);
    bit st, cd, pd;
    build();
    for (int k = 0; k <= e_end + 1; k++) begin
      @(negedge clk);
      if (k == 0)
        chk({nm, "_pre"}, {bus.busy, bus.done, bus.conv_enable, bus.pool_enable, bus.dram_en_rd}, 0);
      else if (rst_at >= 0 && k == rst_at + 1) begin
        chk({nm, "_rst"}, obs(), 0);
        srstn = 1'b1;
        step(0, 0, 0);
        return;
      end else
        chk($sformatf("%s_c%0d", nm, k), obs(), e_out[k]);
      if (k == rst_at) srstn = 1'b0;
      st = (k == 0) || (noise && k <= e_end && $urandom_range(0, 3) == 0);
      cd = cdrv[k] || (noise && !cwait[k] && $urandom_range(0, 3) == 0);
      pd = pdrv[k] || (noise && !pwait[k] && $urandom_range(0, 3) == 0);
      step(st, cd, pd);
    end
  endtask

  task automatic set_tbl(input logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    tbl[0] = a0; tbl[1] = a1; tbl[2] = a2; tbl[3] = a3;
    tbl[4] = a4; tbl[5] = a5; tbl[6] = a6; tbl[7] = a7;
    for (int i = 0; i < NL; i++) begin
      lc[i] = $urandom_range(1, 12); lp[i] = $urandom_range(1, 12);
    end
  endtask

  task automatic rand_tbl();
    int len = $urandom_range(0, NL);
    for (int i = 0; i < NL; i++) begin
      tbl[i] = (i < len) ? 2'($urandom_range(1, 3)) : 2'd0;
      lc[i]  = $urandom_range(1, 12);
      lp[i]  = $urandom_range(1, 12);
    end
  endtask

  initial begin
    int ra;
    srstn = 1'b0; rd_q = 0;
    bus.start = 0; bus.conv_done = 0; bus.pool_done = 0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    chk("reset", obs(), 0);
    srstn = 1'b1;
    gap(3);

    set_tbl(1, 2, 0, 0, 0, 0, 0, 0); lc[0] = 10; lp[1] = 5;
    run("t120", 0, -1); gap(2);
    set_tbl(3, 0, 0, 0, 0, 0, 0, 0);
    run("t30", 0, -1); gap(2);
    set_tbl(0, 0, 0, 0, 0, 0, 0, 0);
    run("t0", 0, -1); gap(2);
    set_tbl(1, 1, 1, 1, 1, 1, 1, 1);
    run("all1", 0, -1); gap(2);
    set_tbl(1, 1, 1, 1, 1, 1, 1, 1);
    run("all1b", 1, -1); gap(1);
    set_tbl(0, 0, 0, 0, 0, 0, 0, 0);
    run("errclr", 0, -1); gap(2);
    set_tbl(1, 2, 0, 0, 0, 0, 0, 0);
    run("noise", 1, -1); gap(2);

    // Reset from IDLE with err set.
    set_tbl(3, 3, 3, 3, 3, 3, 3, 3);
    run("err3", 1, -1);
    @(negedge clk); srstn = 1'b0; step(0, 0, 0);
    @(negedge clk); chk("rst_idle", obs(), 0); srstn = 1'b1;
    gap(2);

    // Reset while waiting on the conv engine in layer 1.
    set_tbl(2, 1, 0, 0, 0, 0, 0, 0); lc[1] = 12;
    build();
    ra = -1;
    for (int k = MAXC - 1; k >= 0; k--)
      if (cwait[k] && e_out[k][20:18] == 3'd1) ra = k;
    run("rstmid", 0, ra + 2);
    gap(3);

    for (int r = 0; r < 24; r++) begin
      rand_tbl();
      run($sformatf("r%0d", r), 1, -1);
      gap($urandom_range(1, 3));
    end

`ifdef SCHED_WDOG_EN
    set_tbl(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      if (k == 3)  chk("wd_go", bus.conv_enable, 1);
      if (k == 19) chk("wd_wait", {bus.busy, bus.done}, 2'b10);
      if (k == 20) chk("wd_done", {bus.done, bus.err}, 2'b11);
      if (k == 21) chk("wd_idle", {bus.busy, bus.err}, 2'b01);
      step(k == 0, 0, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/net_sched.md
Name: net_sched

Overview:
- Top-level layer sequencer for the CNN accelerator.
- Walks a layer descriptor table stored in DRAM. For each layer it launches the convolution engine, the pooling engine, or both in sequence, and waits for each engine's done.
- Shares the DRAM read port with the engines: it drives the port only while it is fetching a descriptor.
- Reports overall completion, or an error, to the host.

Parameters:
- DATA_WIDTH, 32, DRAM data width.
- ADDR_WIDTH, 18, DRAM address width.
- LAYER_TBL_BASE, 18'd32, DRAM word address of descriptor 0.
- MAX_LAYERS, 8, table capacity; layer index width is clog2(MAX_LAYERS).
- WDOG_CYCLES, 1048575, watchdog limit. Used only with SCHED_WDOG_EN.

Ports:
- clk  in  1  clock
- srstn  in  1  synchronous active-low reset
- start  in  1  begin network run; sampled only in IDLE
- data_in  in  DATA_WIDTH  DRAM read data; valid the cycle after the address is driven
- addr_in  out  ADDR_WIDTH  DRAM read address (descriptor fetch)
- dram_en_rd  out  1  DRAM read enable, high only in FETCH
- conv_enable  out  1  one-cycle launch pulse to the conv engine
- conv_done  in  1  conv engine completion pulse
- pool_enable  out  1  one-cycle launch pulse to the pool engine
- pool_done  in  1  pool engine completion pulse
- layer_idx  out  clog2(MAX_LAYERS)  index of the current layer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag; cleared on the next accepted start

Behaviour:
- Reset: srstn low at a clock edge forces state to IDLE. All outputs, layer_idx, op_reg and err go to 0, including mid-run. Engines are not notified.
- Descriptor word: bits [1:0] are op: 0 = END, 1 = CONV, 2 = POOL, 3 = CONV then POOL. Bits [31:2] are reserved and ignored.
- One-hot states: IDLE, FETCH, DECODE, CONV_GO, CONV_WAIT, POOL_GO, POOL_WAIT, NEXT, DONE.
- IDLE:
  - start=1 -> FETCH; layer_idx := 0, err := 0.
  - start is ignored in all other states.
- FETCH: dram_en_rd=1, addr_in = LAYER_TBL_BASE + layer_idx (zero-extended). -> DECODE.
- DECODE: op_reg := data_in[1:0].
  - op 0 -> DONE.
  - op 1 or 3 -> CONV_GO.
  - op 2 -> POOL_GO.
- CONV_GO: conv_enable=1 for exactly this cycle. -> CONV_WAIT.
- CONV_WAIT: hold until conv_done=1.
  - Then -> POOL_GO if op_reg==3, else -> NEXT.
- POOL_GO: pool_enable=1 for one cycle. -> POOL_WAIT.
- POOL_WAIT: on pool_done=1 -> NEXT.
- NEXT:
  - If layer_idx == MAX_LAYERS-1 (table exhausted without END): err := 1, -> DONE.
  - Otherwise layer_idx := layer_idx+1, -> FETCH.
- DONE: done=1 for one cycle. -> IDLE.
- Output decoding: all outputs are Moore-decoded from the state register. addr_in = 0 outside FETCH.
- Stray done pulses: conv_done or pool_done arriving in any state other than its own WAIT state is ignored, and no event is latched.
- Done in the launch cycle: conv_done coincident with CONV_GO is ignored, because the engine cannot finish in zero cycles. The same applies to pool_done in POOL_GO.
- Latency:
  - start to conv_enable = 3 cycles (FETCH, DECODE, CONV_GO).
  - conv_done to the next layer's launch = 4 cycles.
  - An END descriptor at index 0 gives done 3 cycles after start.

Optional Feature:
- Macro: SCHED_WDOG_EN.
- With the macro defined:
  - A 20-bit counter clears on entry to CONV_WAIT or POOL_WAIT and increments every cycle while in either state.
  - When the count reaches WDOG_CYCLES without the awaited done: err := 1, -> DONE.
- Without the macro: no counter exists, and the WAIT states hold indefinitely.

Test Plan:
- Table {1,2,0}, conv_done 10 cycles after conv_enable, pool_done 5 cycles after pool_enable -> conv_enable at start+3; pool_enable 4 cycles after conv_done; layer_idx 0,1,2; done once; err=0.
- Table {3,0} -> conv_enable, then pool_enable 1 cycle after conv_done; layer_idx stays 0 until NEXT; done with err=0.
- Table {0} -> done at start+3; no enable pulses; addr_in=32 during FETCH.
- All 8 entries = 1 -> 8 conv launches, then done with err=1; a second start clears err.
- Stray conv_done in IDLE and in POOL_WAIT, plus start asserted while busy -> no state change, no extra launches.
- srstn low during CONV_WAIT -> next cycle IDLE, busy=0, layer_idx=0. With SCHED_WDOG_EN and WDOG_CYCLES=16 and conv_done withheld -> err=1 and done after 16 wait cycles.
